// File: rtl/raster_capture_if.sv
// Raster stream in, framebuffer write port and status out.
// enable is a valid-only strobe (no ready): a pixel is consumed on every rising clk edge that samples enable high.
interface raster_capture_if #(
   parameter int COLOUR_W = 3,
   parameter int ADDR_W   = 17
);
   logic                enable;
   logic [8:0]          x;
   logic [7:0]          y;
   logic [COLOUR_W-1:0] colour;
   logic [ADDR_W-1:0]   fb_addr;
   logic [COLOUR_W-1:0] fb_data;
   logic                fb_we;
   logic                locked;
   logic                frame_done;
   logic [7:0]          frame_count;
   logic                sync_err;
   logic [7:0]          err_count;

   modport master (
      output enable, x, y, colour,
      input  fb_addr, fb_data, fb_we, locked, frame_done, frame_count, sync_err, err_count
   );

   modport slave (
      input  enable, x, y, colour,
      output fb_addr, fb_data, fb_we, locked, frame_done, frame_count, sync_err, err_count
   );
endinterface

// File: rtl/raster_capture.sv
// Locks onto a raster stream at (0,0), enforces strict raster order and turns
// each accepted pixel into a framebuffer write one cycle later.
module raster_capture #(
   parameter int H_RES    = 320,
   parameter int V_RES    = 240,
   parameter int COLOUR_W = 3,
   parameter int ADDR_W   = 17
) (
   input logic             clk,
   input logic             resetn,
   raster_capture_if.slave bus
);
   typedef enum logic {SEARCH, LOCKED} state_t;

   localparam logic [8:0]        X_LAST      = 9'(H_RES - 1);
   localparam logic [7:0]        Y_LAST      = 8'(V_RES - 1);
   localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_RES);

   state_t              state_q, state_d;
   logic [8:0]          ex_q, ex_d;
   logic [7:0]          ey_q, ey_d;
   logic                accept, last_px, mismatch;
   logic                is_origin, in_range, is_expected, line_end, frame_end;
   logic [ADDR_W-1:0]   addr_calc;
   logic [ADDR_W-1:0]   fb_addr_q;
   logic [COLOUR_W-1:0] fb_data_q;
   logic                fb_we_q, frame_done_q, sync_err_q;
   logic [7:0]          frame_count_q, err_count_q;

   assign is_origin   = (bus.x == 9'd0) && (bus.y == 8'd0);
   assign in_range    = (bus.x <= X_LAST) && (bus.y <= Y_LAST);
   assign is_expected = in_range && (bus.x == ex_q) && (bus.y == ey_q);
   assign line_end    = (ex_q == X_LAST);
   assign frame_end   = line_end && (ey_q == Y_LAST);
   assign addr_calc   = ADDR_W'(bus.y) * LINE_STRIDE + ADDR_W'(bus.x);

   always_comb begin
      state_d  = state_q;
      ex_d     = ex_q;
      ey_d     = ey_q;
      accept   = 1'b0;
      last_px  = 1'b0;
      mismatch = 1'b0;
      if (bus.enable) begin
         case (state_q)
            SEARCH: begin
               if (is_origin) begin
                  accept  = 1'b1;
                  state_d = LOCKED;
                  ex_d    = 9'd1;
                  ey_d    = 8'd0;
               end
            end
            LOCKED: begin
               if (is_expected) begin
                  accept = 1'b1;
                  if (frame_end) begin
                     last_px = 1'b1;
                     ex_d    = 9'd0;
                     ey_d    = 8'd0;
                  end else if (line_end) begin
                     ex_d = 9'd0;
                     ey_d = ey_q + 8'd1;
                  end else begin
                     ex_d = ex_q + 9'd1;
                  end
               end else begin
                  mismatch = 1'b1;
                  // A stray frame start is taken as the new reference instead of dropping lock.
                  if (is_origin) begin
                     accept = 1'b1;
                     ex_d   = 9'd1;
                     ey_d   = 8'd0;
                  end else begin
                     state_d = SEARCH;
                     ex_d    = 9'd0;
                     ey_d    = 8'd0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= SEARCH;
         ex_q          <= 9'd0;
         ey_q          <= 8'd0;
         fb_addr_q     <= '0;
         fb_data_q     <= '0;
         fb_we_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         sync_err_q    <= 1'b0;
         frame_count_q <= 8'd0;
         err_count_q   <= 8'd0;
      end else begin
         state_q      <= state_d;
         ex_q         <= ex_d;
         ey_q         <= ey_d;
         fb_we_q      <= accept;
         frame_done_q <= last_px;
         sync_err_q   <= mismatch;
         if (accept) begin
            fb_addr_q <= addr_calc;
            fb_data_q <= bus.colour;
         end
         if (last_px) frame_count_q <= frame_count_q + 8'd1;
         if (mismatch && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
      end
   end

   assign bus.fb_addr     = fb_addr_q;
   assign bus.fb_data     = fb_data_q;
   assign bus.fb_we       = fb_we_q;
   assign bus.locked      = (state_q == LOCKED);
   assign bus.frame_done  = frame_done_q;
   assign bus.frame_count = frame_count_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_raster_capture.sv
// Directed bench: a small-raster instance for whole-frame and counter-wrap
// behaviour, and a default 320x240 instance for address arithmetic.
module tb_raster_capture;
  localparam int SH = 12;
  localparam int SV = 5;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  raster_capture_if #(.COLOUR_W(3), .ADDR_W(6))  s_if ();
  raster_capture_if #(.COLOUR_W(3), .ADDR_W(17)) b_if ();

  raster_capture #(.H_RES(SH), .V_RES(SV), .COLOUR_W(3), .ADDR_W(6)) dut_s (
    .clk(clk), .resetn(resetn), .bus(s_if.slave)
  );

  raster_capture dut_b (
    .clk(clk), .resetn(resetn), .bus(b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present one sample on the small instance; return 1 time unit after the edge.
  task automatic spx(input logic en, input int px, input int py, input int col);
    @(negedge clk);
    s_if.enable = en;
    s_if.x      = 9'(px);
    s_if.y      = 8'(py);
    s_if.colour = 3'(col);
    @(posedge clk);
    #1;
  endtask

  task automatic bpx(input logic en, input int px, input int py, input int col);
    @(negedge clk);
    b_if.enable = en;
    b_if.x      = 9'(px);
    b_if.y      = 8'(py);
    b_if.colour = 3'(col);
    @(posedge clk);
    #1;
  endtask

  task automatic check_s_write(input string tag, input int px, input int py, input int col);
    check({tag, "_we"},   32'(s_if.fb_we),   1);
    check({tag, "_addr"}, 32'(s_if.fb_addr), py * SH + px);
    check({tag, "_data"}, 32'(s_if.fb_data), col & 7);
  endtask

  task automatic check_s_zero(input string tag);
    check({tag, "_addr"},  32'(s_if.fb_addr),     0);
    check({tag, "_data"},  32'(s_if.fb_data),     0);
    check({tag, "_we"},    32'(s_if.fb_we),       0);
    check({tag, "_lock"},  32'(s_if.locked),      0);
    check({tag, "_fdone"}, 32'(s_if.frame_done),  0);
    check({tag, "_fcnt"},  32'(s_if.frame_count), 0);
    check({tag, "_serr"},  32'(s_if.sync_err),    0);
    check({tag, "_ecnt"},  32'(s_if.err_count),   0);
  endtask

  initial begin
    s_if.enable = 1'b0; s_if.x = '0; s_if.y = '0; s_if.colour = '0;
    b_if.enable = 1'b0; b_if.x = '0; b_if.y = '0; b_if.colour = '0;

    // Asynchronous reset, observed before any clock edge
    #2 resetn = 1'b0;
    #1 check_s_zero("rst");
    check("rst_b_lock", 32'(b_if.locked), 0);
    check("rst_b_addr", 32'(b_if.fb_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // Searching: nothing written until (0,0)
    for (int py = 3; py < SV; py++) begin
      for (int px = (py == 3) ? 5 : 0; px < SH; px++) begin
        spx(1'b1, px, py, px);
        check("search_we", 32'(s_if.fb_we), 0);
        check("search_serr", 32'(s_if.sync_err), 0);
        check("search_lock", 32'(s_if.locked), 0);
      end
    end
    spx(1'b1, 0, 0, 0);
    check_s_write("lock", 0, 0, 0);
    check("lock_locked", 32'(s_if.locked), 1);

    // Rest of a full frame in raster order
    for (int py = 0; py < SV; py++) begin
      for (int px = 0; px < SH; px++) begin
        if (px != 0 || py != 0) begin
          spx(1'b1, px, py, px);
          check_s_write("frame", px, py, px);
          check("frame_fdone", 32'(s_if.frame_done), 32'(px == SH - 1 && py == SV - 1));
          check("frame_serr", 32'(s_if.sync_err), 0);
        end
      end
    end
    check("frame_fcnt", 32'(s_if.frame_count), 1);
    check("frame_ecnt", 32'(s_if.err_count), 0);
    check("frame_lock", 32'(s_if.locked), 1);

    // Out-of-order pixel drops lock
    for (int px = 0; px <= 10; px++) spx(1'b1, px, 0, 1);
    check_s_write("pre_err", 10, 0, 1);
    spx(1'b1, 5, 0, 1);
    check("err_serr", 32'(s_if.sync_err), 1);
    check("err_ecnt", 32'(s_if.err_count), 1);
    check("err_we", 32'(s_if.fb_we), 0);
    check("err_lock", 32'(s_if.locked), 0);
    spx(1'b1, 6, 0, 1);
    check("lost_we", 32'(s_if.fb_we), 0);
    check("lost_serr", 32'(s_if.sync_err), 0);
    spx(1'b1, 0, 0, 2);
    check_s_write("relock", 0, 0, 2);
    check("relock_lock", 32'(s_if.locked), 1);

    // (0,0) mid-frame resyncs while staying locked
    for (int py = 0; py <= 1; py++)
      for (int px = (py == 0) ? 1 : 0; px <= ((py == 1) ? 7 : SH - 1); px++)
        spx(1'b1, px, py, 3);
    check_s_write("pre_resync", 7, 1, 3);
    spx(1'b1, 0, 0, 6);
    check_s_write("resync", 0, 0, 6);
    check("resync_serr", 32'(s_if.sync_err), 1);
    check("resync_fdone", 32'(s_if.frame_done), 0);
    check("resync_lock", 32'(s_if.locked), 1);
    check("resync_ecnt", 32'(s_if.err_count), 2);
    spx(1'b1, 1, 0, 3);
    check_s_write("post_resync", 1, 0, 3);
    check("post_resync_serr", 32'(s_if.sync_err), 0);

    // enable toggling: holds on low samples, contiguous writes on high ones
    for (int px = 2; px < SH; px++) begin
      spx(1'b1, px, 0, px);
      check_s_write("tog_hi", px, 0, px);
      spx(1'b0, 7, 3, 5);
      check("tog_lo_we", 32'(s_if.fb_we), 0);
      check("tog_lo_addr", 32'(s_if.fb_addr), px);
      check("tog_lo_data", 32'(s_if.fb_data), px & 7);
      check("tog_lo_serr", 32'(s_if.sync_err), 0);
    end
    check("tog_ecnt", 32'(s_if.err_count), 2);

    // Out-of-range while searching is ignored; enable-low (0,0) does not lock
    spx(1'b1, 3, 3, 0);
    check("oor_err_ecnt", 32'(s_if.err_count), 3);
    check("oor_err_lock", 32'(s_if.locked), 0);
    spx(1'b1, SH, 0, 0);
    check("oor_we", 32'(s_if.fb_we), 0);
    check("oor_serr", 32'(s_if.sync_err), 0);
    spx(1'b0, 0, 0, 0);
    check("dis_lock", 32'(s_if.locked), 0);
    check("dis_we", 32'(s_if.fb_we), 0);
    spx(1'b1, 0, 0, 4);
    check_s_write("oor_relock", 0, 0, 4);

    // Repeated (0,0) resyncs saturate err_count
    for (int i = 1; i <= 300; i++) begin
      spx(1'b1, 0, 0, 1);
      check("sat_serr", 32'(s_if.sync_err), 1);
      check("sat_we", 32'(s_if.fb_we), 1);
      if (i == 251) check("sat_ecnt_254", 32'(s_if.err_count), 254);
      if (i == 252) check("sat_ecnt_255", 32'(s_if.err_count), 255);
    end
    check("sat_ecnt", 32'(s_if.err_count), 255);
    check("sat_lock", 32'(s_if.locked), 1);

    // Finish the current frame (2nd), then run to 257 frames
    for (int py = 0; py < SV; py++)
      for (int px = 0; px < SH; px++)
        if (px != 0 || py != 0) spx(1'b1, px, py, 0);
    check("f2_fcnt", 32'(s_if.frame_count), 2);
    for (int f = 3; f <= 257; f++) begin
      for (int py = 0; py < SV; py++)
        for (int px = 0; px < SH; px++)
          spx(1'b1, px, py, 2);
      check("wrap_fdone", 32'(s_if.frame_done), 1);
      if (f == 255) check("wrap_fcnt_255", 32'(s_if.frame_count), 255);
      if (f == 256) check("wrap_fcnt_0", 32'(s_if.frame_count), 0);
    end
    check("wrap_fcnt", 32'(s_if.frame_count), 1);
    check("wrap_ecnt", 32'(s_if.err_count), 255);

    // Reset mid-frame clears everything without a clock edge
    spx(1'b1, 0, 0, 1);
    spx(1'b1, 1, 0, 1);
    spx(1'b1, 2, 0, 5);
    check_s_write("pre_mrst", 2, 0, 5);
    #2 resetn = 1'b0;
    #1 check_s_zero("mrst");
    @(negedge clk) resetn = 1'b1;
    spx(1'b1, 3, 0, 1);
    check("mrst_we", 32'(s_if.fb_we), 0);
    check("mrst_lock", 32'(s_if.locked), 0);
    spx(1'b1, 0, 0, 5);
    check_s_write("mrst_relock", 0, 0, 5);
    check("mrst_relock_lock", 32'(s_if.locked), 1);

    // Full-size instance: y*320+x across line boundaries, out-of-range x
    bpx(1'b1, 0, 0, 1);
    check("b_lock_we", 32'(b_if.fb_we), 1);
    check("b_lock_addr", 32'(b_if.fb_addr), 0);
    check("b_lock_lock", 32'(b_if.locked), 1);
    for (int py = 0; py <= 2; py++) begin
      for (int px = 0; px <= ((py == 2) ? 5 : 319); px++) begin
        if (px != 0 || py != 0) begin
          bpx(1'b1, px, py, px);
          check("b_we", 32'(b_if.fb_we), 1);
          check("b_addr", 32'(b_if.fb_addr), py * 320 + px);
        end
      end
    end
    check("b_data", 32'(b_if.fb_data), 5);
    bpx(1'b1, 320, 2, 0);
    check("b_oor_serr", 32'(b_if.sync_err), 1);
    check("b_oor_we", 32'(b_if.fb_we), 0);
    check("b_oor_lock", 32'(b_if.locked), 0);
    check("b_oor_ecnt", 32'(b_if.err_count), 1);
    check("b_oor_addr", 32'(b_if.fb_addr), 2 * 320 + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
